// File: rtl/fft_pkg.sv
// Shared FFT constants and sample type, used by the butterfly and the fft1024 top.
package fft_pkg;

    localparam int Q_FRAC = 13;
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/butterfly.sv
// Radix-2 DIT butterfly: yp = (xp + xq*W)/2, yq = (xp - xq*W)/2, one registered stage.
module butterfly
    import fft_pkg::*;
#(
    parameter int PREC = 36
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] xp_real,
    input  logic signed [DATA_W-1:0] xp_imag,
    input  logic signed [DATA_W-1:0] xq_real,
    input  logic signed [DATA_W-1:0] xq_imag,
    input  logic signed [DATA_W-1:0] factor_real,
    input  logic signed [DATA_W-1:0] factor_imag,
    output logic                     valid,
    output logic signed [DATA_W-1:0] yp_real,
    output logic signed [DATA_W-1:0] yp_imag,
    output logic signed [DATA_W-1:0] yq_real,
    output logic signed [DATA_W-1:0] yq_imag
);

    localparam logic signed [PREC-1:0] SAT_MAX = {{(PREC-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PREC-1:0] SAT_MIN = {{(PREC-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [PREC-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{(PREC-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [PREC-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else                  return v[DATA_W-1:0];
    endfunction

    logic signed [PREC-1:0] pr, pi, t_re, t_im;
    logic signed [PREC-1:0] s_re, s_im, d_re, d_im;
    logic signed [DATA_W-1:0] yp_real_d, yp_imag_d, yq_real_d, yq_imag_d;
    logic signed [DATA_W-1:0] yp_real_q, yp_imag_q, yq_real_q, yq_imag_q;
    logic                     valid_q;

    // Complex multiply at full precision; the twiddle is applied as given (no conjugate).
    always_comb begin
        pr   = sext(xq_real) * sext(factor_real) - sext(xq_imag) * sext(factor_imag);
        pi   = sext(xq_real) * sext(factor_imag) + sext(xq_imag) * sext(factor_real);
        t_re = pr >>> Q_FRAC;
        t_im = pi >>> Q_FRAC;
        s_re = sext(xp_real) + t_re;
        s_im = sext(xp_imag) + t_im;
        d_re = sext(xp_real) - t_re;
        d_im = sext(xp_imag) - t_im;
        yp_real_d = sat(s_re >>> 1);
        yp_imag_d = sat(s_im >>> 1);
        yq_real_d = sat(d_re >>> 1);
        yq_imag_d = sat(d_im >>> 1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q   <= 1'b0;
            yp_real_q <= '0;
            yp_imag_q <= '0;
            yq_real_q <= '0;
            yq_imag_q <= '0;
        end else begin
            valid_q <= en;
            if (en) begin
                yp_real_q <= yp_real_d;
                yp_imag_q <= yp_imag_d;
                yq_real_q <= yq_real_d;
                yq_imag_q <= yq_imag_d;
            end
        end
    end

    assign valid   = valid_q;
    assign yp_real = yp_real_q;
    assign yp_imag = yp_imag_q;
    assign yq_real = yq_real_q;
    assign yq_imag = yq_imag_q;

endmodule

// File: tb/tb_butterfly.sv
// Scoreboard bench for the butterfly: directed scenarios, reset cases and a random sweep.
module tb_butterfly;

    typedef struct {
        logic signed [15:0] ypr;
        logic signed [15:0] ypi;
        logic signed [15:0] yqr;
        logic signed [15:0] yqi;
    } res_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    logic signed [15:0] xp_real = '0, xp_imag = '0, xq_real = '0, xq_imag = '0;
    logic signed [15:0] factor_real = '0, factor_imag = '0;
    logic valid;
    logic signed [15:0] yp_real, yp_imag, yq_real, yq_imag;

    int   pass_cnt = 0;
    int   total = 0;
    res_t sb[$];
    res_t last;

    always #5 clk = ~clk;

    butterfly #(.PREC(36)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .xp_real(xp_real), .xp_imag(xp_imag),
        .xq_real(xq_real), .xq_imag(xq_imag),
        .factor_real(factor_real), .factor_imag(factor_imag),
        .valid(valid),
        .yp_real(yp_real), .yp_imag(yp_imag),
        .yq_real(yq_real), .yq_imag(yq_imag)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic signed [15:0] sat16(input longint v);
        if (v > 32767)       return 16'sh7FFF;
        else if (v < -32768) return 16'sh8000;
        else                 return 16'(v);
    endfunction

    function automatic res_t model(input logic signed [15:0] apr, api, aqr, aqi, wr, wi);
        longint pr, pi, tr, ti;
        res_t r;
        pr = longint'(aqr) * longint'(wr) - longint'(aqi) * longint'(wi);
        pi = longint'(aqr) * longint'(wi) + longint'(aqi) * longint'(wr);
        tr = pr >>> 13;
        ti = pi >>> 13;
        r.ypr = sat16((longint'(apr) + tr) >>> 1);
        r.ypi = sat16((longint'(api) + ti) >>> 1);
        r.yqr = sat16((longint'(apr) - tr) >>> 1);
        r.yqi = sat16((longint'(api) - ti) >>> 1);
        return r;
    endfunction

    task automatic check_outs(input string tag, input res_t e);
        chk({tag, ".yp_real"}, int'(yp_real), int'(e.ypr));
        chk({tag, ".yp_imag"}, int'(yp_imag), int'(e.ypi));
        chk({tag, ".yq_real"}, int'(yq_real), int'(e.yqr));
        chk({tag, ".yq_imag"}, int'(yq_imag), int'(e.yqi));
    endtask

    // Drive one edge; when e=1 the expected result is queued and popped after the edge.
    task automatic step(input string tag, input logic e,
                        input logic signed [15:0] apr, api, aqr, aqi, wr, wi,
                        input res_t expv);
        res_t got;
        en = e;
        xp_real = apr; xp_imag = api; xq_real = aqr; xq_imag = aqi;
        factor_real = wr; factor_imag = wi;
        if (e) sb.push_back(expv);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, int'(valid), int'(e));
        if (e && sb.size() > 0) begin
            got = sb.pop_front();
            last = got;
        end else begin
            got = last;
        end
        check_outs(tag, got);
    endtask

    task automatic mstep(input string tag, input logic e,
                         input logic signed [15:0] apr, api, aqr, aqi, wr, wi);
        step(tag, e, apr, api, aqr, aqi, wr, wi, model(apr, api, aqr, aqi, wr, wi));
    endtask

    function automatic logic signed [15:0] rnd16();
        if ($urandom_range(0, 7) == 0) return 16'sh8000;
        return 16'($urandom);
    endfunction

    initial begin
        res_t z;
        z = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        last = z;

        // Reset state
        #2;
        chk("reset.valid", int'(valid), 0);
        check_outs("reset", z);
        @(negedge clk);
        rstn = 1'b1;

        // Scenario 1..3 with hand-computed expectations
        step("s1", 1'b1, 16'sd1000, 16'sd0, 16'sd200, 16'sd0, 16'sh2000, 16'sd0,
             '{16'sd600, 16'sd0, 16'sd400, 16'sd0});
        step("s2", 1'b1, 16'sd1000, 16'sd0, 16'sd200, 16'sd100, 16'sd0, -16'sh2000,
             '{16'sd550, -16'sd100, 16'sd450, 16'sd100});
        step("s3", 1'b1, 16'sd32767, 16'sd0, 16'sd32767, -16'sd32767, 16'sh2000, 16'sh2000,
             '{16'sd32767, 16'sd0, -16'sd16384, 16'sd0});

        // Scenario 4: three back-to-back results then hold
        mstep("s4a", 1'b1, 16'sd100, -16'sd50, 16'sd300, 16'sd20, 16'sh1000, 16'sh0800);
        mstep("s4b", 1'b1, -16'sd700, 16'sd900, -16'sd40, 16'sd60, -16'sh2000, 16'sd0);
        mstep("s4c", 1'b1, 16'sd1, -16'sd3, 16'sd7, -16'sd5, 16'sh1234, -16'sh0567);
        mstep("s4hold0", 1'b0, 16'sd5000, 16'sd5000, 16'sd5000, 16'sd5000, 16'sh2000, 16'sd0);
        mstep("s4hold1", 1'b0, -16'sd5000, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5);

        // Scenario 5: asynchronous reset while valid is high
        mstep("s5pre", 1'b1, 16'sd1234, 16'sd4321, -16'sd999, 16'sd888, 16'sh1F00, -16'sh0100);
        #3;
        rstn = 1'b0;
        #1;
        chk("s5async.valid", int'(valid), 0);
        check_outs("s5async", z);
        last = z;
        #2;
        rstn = 1'b1;
        mstep("s5idle", 1'b0, 16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sh2000, 16'sd0);
        mstep("s5first", 1'b1, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sh8000, -16'sh8000);

        // Scenario 6: random sweep with random en
        for (int i = 0; i < 10000; i++) begin
            mstep("rand", ($urandom_range(0, 3) != 0), rnd16(), rnd16(), rnd16(), rnd16(),
                  rnd16(), rnd16());
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
